ibex_cx_dispatch: RTL and testbench
===================================

Name: ibex_cx_dispatch

Overview:
Execute-side dispatcher for custom composable-extension instructions (opcodes CX_REG 0x0b, CX_IMM 0x2b, CX_FLEX 0x5b). It sits downstream of the ID stage and the CSR file. It takes a decoded CX instruction plus the MCX_SEL CSR value, issues a valid/ready request to the selected accelerator, and waits for its response. It then returns the result to register writeback and maintains the sticky status word exposed as CSR CX_STAT.

Parameters:
NUM_CX, 4, number of attached accelerators (1..16)
TIMEOUT_CYCLES, 255, response wait limit in cycles (1..65535)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
instr_valid_i  in  1  ID presents a CX-class instruction
instr_ready_o  out  1  dispatcher accepts the instruction (IDLE only)
opcode_i  in  7  opcode_e of the instruction
funct_i  in  10  {funct7, funct3}
operand_a_i  in  32  rs1 value
operand_b_i  in  32  rs2 value, or immediate for CX_IMM
rd_addr_i  in  5  destination register
flush_i  in  1  controller kill of the in-flight instruction
mcx_sel_i  in  32  MCX_SEL CSR: [31] enable, [3:0] cx_id
cx_req_valid_o  out  1  request valid
cx_req_ready_i  in  1  accelerator accepts request
cx_req_id_o  out  4  target accelerator
cx_req_func_o  out  10  funct passthrough
cx_req_a_o  out  32  operand a
cx_req_b_o  out  32  operand b
cx_resp_valid_i  in  1  response valid
cx_resp_ready_o  out  1  dispatcher accepts response
cx_resp_data_i  in  32  result
cx_resp_status_i  in  2  0 = OK, nonzero = accelerator error code
wb_valid_o  out  1  one-cycle regfile write strobe
wb_rd_addr_o  out  5  write address
wb_data_o  out  32  write data
illegal_o  out  1  one-cycle pulse, raises EXC_CAUSE_ILLEGAL_INSN
busy_o  out  1  state != IDLE (stalls ID)
cx_status_o  out  32  CX_STAT value
cx_status_clr_i  in  1  CSR write clears the sticky bits

Behaviour:
- FSM states: IDLE, REQ, RESP, WB. Reset enters IDLE. On reset, every output is 0 except instr_ready_o = 1. cx_status_o resets to 0.
- IDLE: instr_ready_o = 1.
  - Accept on instr_valid_i when opcode_i is one of the three CX opcodes, mcx_sel_i[31] = 1 and mcx_sel_i[3:0] < NUM_CX.
  - On accept, latch id, funct, operands and rd, then go to REQ.
  - If the opcode is not CX, the enable bit is 0, or the id is >= NUM_CX: pulse illegal_o the next cycle, set status[2], stay in IDLE.
- REQ: cx_req_valid_o = 1 with payload held stable until cx_req_ready_i. On handshake go to RESP and clear the timer.
- RESP: cx_resp_ready_o = 1 and the timer counts up each cycle.
  - On cx_resp_valid_i: latch data and status, go to WB.
  - When the timer reaches TIMEOUT_CYCLES without a response: data = 0, set status[1], go to WB.
  - A response in the same cycle as the timeout wins; the timeout is not flagged.
- WB: wb_valid_o = 1 for one cycle, unless rd = 0 or the discard flag is set. Then return to IDLE.
  - If the response status is nonzero: set status[0], still write the data.
- Minimum latency from accept edge to wb_valid_o is 3 cycles (REQ 1, RESP 1, WB 1).
- flush_i handling:
  - In IDLE: no effect.
  - In REQ without handshake that cycle: drop valid, return to IDLE. Dropping valid is permitted by this protocol only on flush.
  - In REQ with handshake in the same cycle, or in RESP: set discard and continue. The response is still consumed, but wb_valid_o is suppressed.
  - In WB: suppress the write.
- cx_status_o fields:
  - [0] error, sticky
  - [1] timeout, sticky
  - [2] illegal, sticky
  - [7:4] last dispatched id
  - [9:8] last response status
  - all other bits 0
- cx_status_clr_i clears bits [2:0]. If a set event and a clear occur in the same cycle, set wins.
- Reset mid-operation: return to IDLE immediately and drop all handshakes. An accelerator's late response is ignored because cx_resp_ready_o is 0.
- Timer width is $clog2(TIMEOUT_CYCLES+1) and it saturates; there is no wrap.

Decomposition:
- ibex_defines: cx_state_e, cx_resp_status_e, MCX_SEL_EN_BIT = 31, CX_STAT bit index localparams.
- One sub-module, ibex_cx_timer: clear/enable saturating counter with an expired flag.

Test Plan:
- mcx_sel = 0x8000_0001, CX_REG, a = 5, b = 7, accelerator ready immediately and responds with 0x0C the next cycle -> wb_valid_o at accept+3, rd = 3, data 0x0C, status[7:4] = 1.
- mcx_sel = 0x0000_0001 (disabled), CX_IMM -> illegal_o one pulse, no cx_req_valid_o, status[2] = 1; cx_status_clr_i then clears it.
- NUM_CX = 4, mcx_sel = 0x8000_0005 -> illegal_o. Separately, valid id with cx_req_ready_i held low 10 cycles -> payload stable for all 10 cycles.
- TIMEOUT_CYCLES = 8, no response -> WB with data 0 after 8 RESP cycles, status[1] = 1. A response on cycle 8 instead -> written, no timeout.
- flush_i in RESP, then response 0xDEAD -> no wb_valid_o, return to IDLE. rd = 0 with an OK response -> no write.
- Response status 2 -> data written, status[0] = 1, [9:8] = 2. rst_i asserted in RESP -> all outputs 0 except instr_ready_o = 1 on the next edge.

Source files
------------

// File: rtl/ibex_cx_dispatch_pkg.sv
// ----------------------------------------------------------------------------
// ibex_cx_dispatch_pkg
// Shared types and constants for the composable-extension (CX) dispatcher:
// dispatcher FSM states, accelerator response codes, the CX opcodes, the
// MCX_SEL enable bit position and the CX_STAT field positions.
// ----------------------------------------------------------------------------
package ibex_cx_dispatch_pkg;

  typedef enum logic [1:0] {
    CX_IDLE = 2'd0,
    CX_REQ  = 2'd1,
    CX_RESP = 2'd2,
    CX_WB   = 2'd3
  } cx_state_e;

  typedef enum logic [1:0] {
    CX_RESP_OK   = 2'd0,
    CX_RESP_ERR1 = 2'd1,
    CX_RESP_ERR2 = 2'd2,
    CX_RESP_ERR3 = 2'd3
  } cx_resp_status_e;

  typedef enum logic [6:0] {
    OPCODE_CX_REG  = 7'h0b,
    OPCODE_CX_IMM  = 7'h2b,
    OPCODE_CX_FLEX = 7'h5b
  } opcode_e;

  localparam int MCX_SEL_EN_BIT = 31;

  // CX_STAT layout
  localparam int CX_STAT_ERR_BIT = 0;
  localparam int CX_STAT_TMO_BIT = 1;
  localparam int CX_STAT_ILL_BIT = 2;
  localparam int CX_STAT_ID_LSB  = 4;
  localparam int CX_STAT_ID_MSB  = 7;
  localparam int CX_STAT_RS_LSB  = 8;
  localparam int CX_STAT_RS_MSB  = 9;

  function automatic logic is_cx_opcode(input logic [6:0] op);
    return (op == OPCODE_CX_REG) || (op == OPCODE_CX_IMM) || (op == OPCODE_CX_FLEX);
  endfunction

endpackage

// File: rtl/ibex_cx_timer.sv
// ----------------------------------------------------------------------------
// ibex_cx_timer
// Saturating response-wait counter.
//   clk_i / rst_i : clock, asynchronous active-high reset
//   clr_i         : return the count to zero (priority over en_i)
//   en_i          : count one more waited cycle
//   expired_o     : the current enabled cycle is the LIMIT-th one
// ----------------------------------------------------------------------------
module ibex_cx_timer #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = $clog2(LIMIT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (en_i && (r_count != W'(LIMIT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds the cycles already waited, so the cycle in which it equals
  // LIMIT-1 is the LIMIT-th waiting cycle. The LIMIT term covers saturation.
  assign expired_o = (r_count == W'(LIMIT - 1)) || (r_count == W'(LIMIT));

endmodule

// File: rtl/ibex_cx_dispatch.sv
// ----------------------------------------------------------------------------
// ibex_cx_dispatch
// Execute-side dispatcher for custom composable-extension instructions.
// Accepts a decoded CX instruction from ID, issues a valid/ready request to
// the accelerator chosen by MCX_SEL, waits (bounded) for its response, writes
// the result back to the register file and keeps the CX_STAT status word.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   instr_valid_i/instr_ready_o  instruction handshake from ID
//   opcode_i, funct_i            opcode and {funct7, funct3}
//   operand_a_i, operand_b_i     rs1 and rs2/immediate
//   rd_addr_i                    destination register
//   flush_i                      controller kill of the in-flight instruction
//   mcx_sel_i                    [31] enable, [3:0] accelerator id
//   cx_req_*                     request channel to the accelerators
//   cx_resp_*                    response channel from the accelerators
//   wb_valid_o/wb_rd_addr_o/wb_data_o  register file write port
//   illegal_o                    one-cycle illegal-instruction pulse
//   busy_o                       dispatcher occupied, stalls ID
//   cx_status_o, cx_status_clr_i CX_STAT value and sticky-bit clear
// ----------------------------------------------------------------------------
module ibex_cx_dispatch
  import ibex_cx_dispatch_pkg::*;
#(
  parameter int unsigned NUM_CX         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [9:0]  funct_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  input  logic [31:0] mcx_sel_i,
  output logic        cx_req_valid_o,
  input  logic        cx_req_ready_i,
  output logic [3:0]  cx_req_id_o,
  output logic [9:0]  cx_req_func_o,
  output logic [31:0] cx_req_a_o,
  output logic [31:0] cx_req_b_o,
  input  logic        cx_resp_valid_i,
  output logic        cx_resp_ready_o,
  input  logic [31:0] cx_resp_data_i,
  input  logic [1:0]  cx_resp_status_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,
  output logic        illegal_o,
  output logic        busy_o,
  output logic [31:0] cx_status_o,
  input  logic        cx_status_clr_i
);

  cx_state_e   r_state;
  cx_state_e   w_state_next;

  logic [3:0]  r_id;
  logic [9:0]  r_func;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_rd;
  logic        r_discard;
  logic [31:0] r_data;
  logic        r_illegal;

  logic        r_err;
  logic        r_tmo;
  logic        r_ill;
  logic [3:0]  r_last_id;
  logic [1:0]  r_last_status;

  logic [3:0]  w_sel_id;
  logic        w_sel_en;
  logic        w_id_ok;
  logic        w_legal;
  logic        w_accept;
  logic        w_illegal;
  logic        w_req_hs;
  logic        w_resp_hs;
  logic        w_tmr_expired;
  logic        w_timeout;
  logic        w_set_err;
  logic [31:0] w_status;

  // --------------------------------------------------------------------------
  // Instruction qualification
  // --------------------------------------------------------------------------
  assign w_sel_id  = mcx_sel_i[3:0];
  assign w_sel_en  = mcx_sel_i[MCX_SEL_EN_BIT];
  // One extra bit so NUM_CX = 16 is representable.
  assign w_id_ok   = ({1'b0, w_sel_id} < 5'(NUM_CX));
  assign w_legal   = is_cx_opcode(opcode_i) && w_sel_en && w_id_ok;

  assign w_accept  = (r_state == CX_IDLE) && instr_valid_i && w_legal;
  assign w_illegal = (r_state == CX_IDLE) && instr_valid_i && !w_legal;
  assign w_req_hs  = (r_state == CX_REQ)  && cx_req_ready_i;
  assign w_resp_hs = (r_state == CX_RESP) && cx_resp_valid_i;
  // A response arriving in the expiry cycle takes precedence.
  assign w_timeout = (r_state == CX_RESP) && !cx_resp_valid_i && w_tmr_expired;
  assign w_set_err = w_resp_hs && (cx_resp_status_i != CX_RESP_OK);

  // --------------------------------------------------------------------------
  // Response wait timer: cleared while requesting, counts while waiting
  // --------------------------------------------------------------------------
  ibex_cx_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (r_state == CX_REQ),
    .en_i      (r_state == CX_RESP),
    .expired_o (w_tmr_expired)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= CX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    instr_ready_o   = 1'b0;
    cx_req_valid_o  = 1'b0;
    cx_resp_ready_o = 1'b0;
    wb_valid_o      = 1'b0;
    busy_o          = 1'b1;
    case (r_state)
      CX_IDLE: begin
        instr_ready_o = 1'b1;
        busy_o        = 1'b0;
        if (w_accept) begin
          w_state_next = CX_REQ;
        end
      end
      CX_REQ: begin
        cx_req_valid_o = 1'b1;
        // Once the accelerator has taken the request it must be answered,
        // so a flush only aborts a request that has not been accepted yet.
        if (cx_req_ready_i) begin
          w_state_next = CX_RESP;
        end else if (flush_i) begin
          w_state_next = CX_IDLE;
        end
      end
      CX_RESP: begin
        cx_resp_ready_o = 1'b1;
        if (cx_resp_valid_i || w_tmr_expired) begin
          w_state_next = CX_WB;
        end
      end
      CX_WB: begin
        wb_valid_o   = !r_discard && (r_rd != 5'd0) && !flush_i;
        w_state_next = CX_IDLE;
      end
      default: begin
        w_state_next = CX_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: request payload, discard flag, result
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_id      <= '0;
      r_func    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rd      <= '0;
      r_discard <= 1'b0;
      r_data    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_illegal;
      if (w_accept) begin
        r_id      <= w_sel_id;
        r_func    <= funct_i;
        r_a       <= operand_a_i;
        r_b       <= operand_b_i;
        r_rd      <= rd_addr_i;
        r_discard <= 1'b0;
      end else if (flush_i && (w_req_hs || (r_state == CX_RESP))) begin
        r_discard <= 1'b1;
      end
      if (w_resp_hs) begin
        r_data <= cx_resp_data_i;
      end else if (w_timeout) begin
        r_data <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // CX_STAT: sticky bits, set has priority over a same-cycle clear
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err         <= 1'b0;
      r_tmo         <= 1'b0;
      r_ill         <= 1'b0;
      r_last_id     <= '0;
      r_last_status <= '0;
    end else begin
      r_err <= w_set_err | (r_err & ~cx_status_clr_i);
      r_tmo <= w_timeout | (r_tmo & ~cx_status_clr_i);
      r_ill <= w_illegal | (r_ill & ~cx_status_clr_i);
      if (w_accept) begin
        r_last_id <= w_sel_id;
      end
      if (w_resp_hs) begin
        r_last_status <= cx_resp_status_i;
      end
    end
  end

  always_comb begin
    w_status                                 = '0;
    w_status[CX_STAT_ERR_BIT]                = r_err;
    w_status[CX_STAT_TMO_BIT]                = r_tmo;
    w_status[CX_STAT_ILL_BIT]                = r_ill;
    w_status[CX_STAT_ID_MSB:CX_STAT_ID_LSB]  = r_last_id;
    w_status[CX_STAT_RS_MSB:CX_STAT_RS_LSB]  = r_last_status;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cx_req_id_o   = r_id;
  assign cx_req_func_o = r_func;
  assign cx_req_a_o    = r_a;
  assign cx_req_b_o    = r_b;
  assign wb_rd_addr_o  = (r_state == CX_WB) ? r_rd   : 5'd0;
  assign wb_data_o     = (r_state == CX_WB) ? r_data : 32'd0;
  assign illegal_o     = r_illegal;
  assign cx_status_o   = w_status;

endmodule

// File: tb/tb_ibex_cx_dispatch.sv
module tb_ibex_cx_dispatch;

  localparam int NUM = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [6:0]  opcode = '0;
  logic [9:0]  funct = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd = '0;
  logic        flush = 1'b0;
  logic [31:0] mcx_sel = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [3:0]  req_id;
  logic [9:0]  req_func;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [31:0] resp_data = '0;
  logic [1:0]  resp_status = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic        busy;
  logic [31:0] status;
  logic        status_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ibex_cx_dispatch #(
    .NUM_CX         (NUM),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .instr_valid_i    (instr_valid),
    .instr_ready_o    (instr_ready),
    .opcode_i         (opcode),
    .funct_i          (funct),
    .operand_a_i      (op_a),
    .operand_b_i      (op_b),
    .rd_addr_i        (rd),
    .flush_i          (flush),
    .mcx_sel_i        (mcx_sel),
    .cx_req_valid_o   (req_valid),
    .cx_req_ready_i   (req_ready),
    .cx_req_id_o      (req_id),
    .cx_req_func_o    (req_func),
    .cx_req_a_o       (req_a),
    .cx_req_b_o       (req_b),
    .cx_resp_valid_i  (resp_valid),
    .cx_resp_ready_o  (resp_ready),
    .cx_resp_data_i   (resp_data),
    .cx_resp_status_i (resp_status),
    .wb_valid_o       (wb_valid),
    .wb_rd_addr_o     (wb_rd),
    .wb_data_o        (wb_data),
    .illegal_o        (illegal),
    .busy_o           (busy),
    .cx_status_o      (status),
    .cx_status_clr_i  (status_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level, plain ints) --------
  // phase: 0 waiting for an instruction, 1 offering the request,
  //        2 waiting for the answer, 3 writing back
  int m_phase = 0;
  int m_waited = 0;
  int m_drop = 0;
  int m_id = 0, m_func = 0, m_a = 0, m_b = 0, m_rd = 0, m_data = 0;
  int m_err = 0, m_tmo = 0, m_ill = 0, m_lid = 0, m_lst = 0;
  int m_ill_pulse = 0;

  function automatic bit legal(input logic [6:0] op, input logic [31:0] sel);
    return (op == 7'h0b || op == 7'h2b || op == 7'h5b) && sel[31] && (int'(sel[3:0]) < NUM);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_waited <= 0; m_drop <= 0;
      m_id <= 0; m_func <= 0; m_a <= 0; m_b <= 0; m_rd <= 0; m_data <= 0;
      m_err <= 0; m_tmo <= 0; m_ill <= 0; m_lid <= 0; m_lst <= 0;
      m_ill_pulse <= 0;
    end else begin
      m_ill_pulse <= (m_phase == 0 && instr_valid && !legal(opcode, mcx_sel)) ? 1 : 0;
      m_ill <= (m_phase == 0 && instr_valid && !legal(opcode, mcx_sel)) ? 1 : (status_clr ? 0 : m_ill);
      m_err <= (m_phase == 2 && resp_valid && resp_status != 2'd0) ? 1 : (status_clr ? 0 : m_err);
      m_tmo <= (m_phase == 2 && !resp_valid && m_waited + 1 == TMO) ? 1 : (status_clr ? 0 : m_tmo);
      case (m_phase)
        0: if (instr_valid && legal(opcode, mcx_sel)) begin
             m_phase <= 1; m_id <= int'(mcx_sel[3:0]); m_lid <= int'(mcx_sel[3:0]);
             m_func <= int'(funct); m_a <= int'(op_a); m_b <= int'(op_b);
             m_rd <= int'(rd); m_drop <= 0;
           end
        1: if (req_ready) begin
             m_phase <= 2; m_waited <= 0; m_drop <= flush ? 1 : 0;
           end else if (flush) begin
             m_phase <= 0;
           end
        2: begin
             if (flush) m_drop <= 1;
             if (resp_valid) begin
               m_phase <= 3; m_data <= int'(resp_data); m_lst <= int'(resp_status);
             end else if (m_waited + 1 == TMO) begin
               m_phase <= 3; m_data <= 0;
             end else begin
               m_waited <= m_waited + 1;
             end
           end
        default: m_phase <= 0;
      endcase
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    chk("instr_ready", 32'(instr_ready), 32'(m_phase == 0));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("req_valid", 32'(req_valid), 32'(m_phase == 1));
    chk("resp_ready", 32'(resp_ready), 32'(m_phase == 2));
    chk("req_id", 32'(req_id), 32'(m_id));
    chk("req_func", 32'(req_func), 32'(m_func));
    chk("req_a", req_a, 32'(m_a));
    chk("req_b", req_b, 32'(m_b));
    chk("wb_valid", 32'(wb_valid), 32'(m_phase == 3 && m_drop == 0 && m_rd != 0 && !flush));
    chk("wb_rd", 32'(wb_rd), (m_phase == 3) ? 32'(m_rd) : 32'd0);
    chk("wb_data", wb_data, (m_phase == 3) ? 32'(m_data) : 32'd0);
    chk("illegal", 32'(illegal), 32'(m_ill_pulse));
    chk("status", status, 32'(m_err + 2 * m_tmo + 4 * m_ill + 16 * m_lid + 256 * m_lst));
  end

  // ---------------- directed stimulus ------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] sel, input logic [6:0] op, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] b, input logic [9:0] f);
    mcx_sel = sel; opcode = op; rd = r; op_a = a; op_b = b; funct = f;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_status", status, 32'd0);
    tick();

    // 1: basic dispatch, immediate handshakes
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = 32'h0C; resp_status = 2'd0;
    issue(32'h8000_0001, 7'h0b, 5'd3, 32'd5, 32'd7, 10'h155);
    tick();
    @(negedge clk);
    chk("t1_no_wb_early", 32'(wb_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_wb_valid", 32'(wb_valid), 32'd1);
    chk("t1_wb_rd", 32'(wb_rd), 32'd3);
    chk("t1_wb_data", wb_data, 32'h0C);
    chk("t1_last_id", 32'(status[7:4]), 32'd1);
    tick();
    resp_valid = 1'b0;

    // 2: disabled selector
    issue(32'h0000_0001, 7'h2b, 5'd3, 32'd1, 32'd2, 10'h0);
    @(negedge clk);
    chk("t2_illegal", 32'(illegal), 32'd1);
    chk("t2_no_req", 32'(req_valid), 32'd0);
    chk("t2_stat_ill", 32'(status[2]), 32'd1);
    tick();
    @(negedge clk);
    chk("t2_pulse_once", 32'(illegal), 32'd0);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    @(negedge clk);
    chk("t2_cleared", 32'(status[2]), 32'd0);

    // 3a: id out of range
    issue(32'h8000_0005, 7'h5b, 5'd3, 32'd1, 32'd2, 10'h0);
    @(negedge clk);
    chk("t3_illegal_id", 32'(illegal), 32'd1);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;

    // 3b: request stalled 10 cycles, payload must hold
    req_ready = 1'b0;
    issue(32'h8000_0002, 7'h0b, 5'd7, 32'h1111, 32'h2222, 10'h3ff);
    op_a = 32'hFFFF_FFFF; op_b = 32'hEEEE_EEEE; funct = 10'h0; mcx_sel = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(req_valid), 32'd1);
      chk("t3_hold_id", 32'(req_id), 32'd2);
      chk("t3_hold_a", req_a, 32'h1111);
      chk("t3_hold_b", req_b, 32'h2222);
      tick();
    end
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = 32'h3333;
    tick(); tick(); tick();
    resp_valid = 1'b0;

    // 4a: timeout after TMO response cycles
    issue(32'h8000_0003, 7'h2b, 5'd4, 32'd9, 32'd9, 10'h1);
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    @(negedge clk);
    chk("t4_still_wait", 32'(resp_ready), 32'd1);
    tick();
    @(negedge clk);
    chk("t4_tmo_wb", 32'(wb_valid), 32'd1);
    chk("t4_tmo_data", wb_data, 32'd0);
    chk("t4_tmo_flag", 32'(status[1]), 32'd1);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;

    // 4b: response in the last allowed cycle wins
    issue(32'h8000_0003, 7'h2b, 5'd4, 32'd9, 32'd9, 10'h1);
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    resp_valid = 1'b1; resp_data = 32'hBEEF;
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    chk("t4b_data", wb_data, 32'hBEEF);
    chk("t4b_no_tmo", 32'(status[1]), 32'd0);
    tick();

    // 5a: flush while waiting for the answer
    issue(32'h8000_0001, 7'h0b, 5'd5, 32'd1, 32'd1, 10'h2);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; resp_valid = 1'b1; resp_data = 32'hDEAD;
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    chk("t5_flush_nowb", 32'(wb_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_idle", 32'(instr_ready), 32'd1);

    // 5b: rd = 0 never writes
    resp_valid = 1'b1; resp_data = 32'h1234;
    issue(32'h8000_0000, 7'h0b, 5'd0, 32'd1, 32'd1, 10'h2);
    tick();
    @(negedge clk);
    chk("t5_rd0_nowb", 32'(wb_valid), 32'd0);
    tick();
    resp_valid = 1'b0;

    // 5c: flush before the request is taken aborts it
    req_ready = 1'b0;
    issue(32'h8000_0001, 7'h0b, 5'd5, 32'd1, 32'd1, 10'h2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_abort_valid", 32'(req_valid), 32'd0);
    chk("t5_abort_idle", 32'(instr_ready), 32'd1);
    req_ready = 1'b1;

    // 6a: accelerator error code
    resp_valid = 1'b1; resp_data = 32'h55; resp_status = 2'd2;
    issue(32'h8000_0003, 7'h5b, 5'd6, 32'd1, 32'd1, 10'h3);
    tick(); tick();
    @(negedge clk);
    chk("t6_wb", 32'(wb_valid), 32'd1);
    chk("t6_data", wb_data, 32'h55);
    chk("t6_err", 32'(status[0]), 32'd1);
    chk("t6_rstat", 32'(status[9:8]), 32'd2);
    tick();
    resp_valid = 1'b0; resp_status = 2'd0;

    // 6b: reset while waiting for the answer
    issue(32'h8000_0002, 7'h0b, 5'd8, 32'd1, 32'd1, 10'h3);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(instr_ready), 32'd1);
    chk("t6_rst_resp_rdy", 32'(resp_ready), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_status", status, 32'd0);
    tick();
    rst = 1'b0;
    resp_valid = 1'b1; resp_data = 32'h7777;
    @(negedge clk);
    chk("t6_late_ignored", 32'(resp_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("t6_late_nowb", 32'(wb_valid), 32'd0);
    resp_valid = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
